// File: rtl/inst_sram_axi_responder_pkg.sv
// Shared constants and types for the instruction-side sram-like to AXI3
// read responder.
//   INST_ARID      : AXI ID used for every instruction read
//   AXI_BURST_INCR : AXI3 burst encoding for INCR
//   AXI_RESP_OKAY  : AXI3 OKAY response code
//   CNT_W          : width of the outstanding-request counter
//   ar_req_t       : contents of the AR holding register
package inst_sram_axi_responder_pkg;

  localparam logic [3:0] INST_ARID      = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         CNT_W          = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
  } ar_req_t;

endpackage

// File: rtl/inst_sram_axi_responder.sv
// Instruction sram-like slave feeding the fetch stage. Every accepted fetch
// request becomes one single-beat AXI3 read on a fixed ID; read data comes
// back to the fetch stage strictly in request order, one data_ok per addr_ok.
//
// Ports
//   clk, reset            : core clock, asynchronous active-high reset
//   inst_sram_req/size/addr : fetch request
//   inst_sram_addr_ok     : request accepted this cycle (combinational)
//   inst_sram_data_ok     : one-cycle pulse, inst_sram_rdata valid
//   inst_sram_rdata       : returned instruction (holds last value)
//   inst_sram_rerr        : sticky error (bad rresp or unexpected R beat)
//   ar*                   : AXI3 read-address channel (master side)
//   r*                    : AXI3 read-data channel (master side)
module inst_sram_axi_responder
  import inst_sram_axi_responder_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [3:0] ARID_VAL        = INST_ARID
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_rerr,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_req_t           ar_q;
  logic [CNT_W-1:0]  out_cnt;
  logic              r_fire;
  logic              ar_free;
  logic              has_room;
  logic              accept;
  logic              beat_ok;
  logic              beat_err;

  // Single fixed ID with single-beat bursts: rid and rlast carry nothing the
  // in-order return path needs.
  logic unused_r;
  assign unused_r = ^{rid, rlast};

  assign arid    = ARID_VAL;
  assign araddr  = ar_q.addr;
  assign arsize  = {1'b0, ar_q.size};
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign r_fire = rvalid && rready;

  // The holding register can take a new request when it is empty or is
  // being emptied by the AR handshake this cycle.
  assign ar_free = !arvalid || arready;

  // A response retiring this cycle frees a slot, so a full responder can
  // still accept. Only rvalid reaches addr_ok, never rdata.
  assign has_room = (out_cnt < MAX_CNT) || r_fire;

  assign inst_sram_addr_ok = inst_sram_req && ar_free && has_room;
  assign accept            = inst_sram_addr_ok;

  // An R beat with nothing outstanding has no fetch to answer: it is
  // flagged but never forwarded and never decrements the counter.
  assign beat_ok  = r_fire && (out_cnt != '0);
  assign beat_err = r_fire && ((rresp != AXI_RESP_OKAY) || (out_cnt == '0));

  // AR holding register. A handshake and a new accept in the same cycle keep
  // arvalid high with the new address, giving one AR per cycle.
  // NOTE: all state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid <= 1'b0;
      ar_q    <= '0;
    end else if (accept) begin
      arvalid <= 1'b1;
      ar_q    <= '{addr: inst_sram_addr, size: inst_sram_size};
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // Accepted-but-unanswered requests, including one still in the AR
  // holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
    end else begin
      case ({accept, beat_ok})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // R capture. rready rises on the first clock after reset and stays high:
  // the fetch stage buffers data_ok itself, so R is never back-pressured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rready            <= 1'b0;
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= '0;
      inst_sram_rerr    <= 1'b0;
    end else begin
      rready            <= 1'b1;
      inst_sram_data_ok <= beat_ok;
      if (beat_ok) begin
        inst_sram_rdata <= rdata;
      end
      if (beat_err) begin
        inst_sram_rerr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_responder.sv
module tb_inst_sram_axi_responder;

  localparam int          MAX_OUT = 4;
  localparam logic [31:0] KEY     = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req = 1'b0;
  logic [1:0]  inst_sram_size = 2'd2;
  logic [31:0] inst_sram_addr = '0;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_rerr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  inst_sram_axi_responder #(.MAX_OUTSTANDING(MAX_OUT), .ARID_VAL(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .inst_sram_rerr(inst_sram_rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the
  // falling edge of the same cycle.
  task automatic cyc(input logic req, input logic [31:0] addr, input logic ar_rdy,
                     input logic rv, input logic [31:0] rd, input logic [1:0] resp);
    @(posedge clk);
    #1;
    inst_sram_req  = req;
    inst_sram_addr = addr;
    arready        = ar_rdy;
    rvalid         = rv;
    rdata          = rd;
    rresp          = resp;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00);
  endtask

  task automatic expect_out(input string tag, input logic aok, input logic arv,
                            input logic [31:0] ara, input logic dok,
                            input logic [31:0] rd, input logic err);
    check({tag, ".addr_ok"}, 32'(inst_sram_addr_ok), 32'(aok));
    check({tag, ".arvalid"}, 32'(arvalid), 32'(arv));
    check({tag, ".araddr"},  araddr, ara);
    check({tag, ".data_ok"}, 32'(inst_sram_data_ok), 32'(dok));
    check({tag, ".rdata"},   inst_sram_rdata, rd);
    check({tag, ".rerr"},    32'(inst_sram_rerr), 32'(err));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".arvalid"}, 32'(arvalid), 32'd0);
    check({tag, ".araddr"},  araddr, 32'd0);
    check({tag, ".arsize"},  32'(arsize), 32'd0);
    check({tag, ".data_ok"}, 32'(inst_sram_data_ok), 32'd0);
    check({tag, ".rdata"},   inst_sram_rdata, 32'd0);
    check({tag, ".rerr"},    32'(inst_sram_rerr), 32'd0);
    check({tag, ".rready"},  32'(rready), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #1;
    reset          = 1'b1;
    inst_sram_req  = 1'b0;
    inst_sram_addr = '0;
    arready        = 1'b0;
    rvalid         = 1'b0;
    rdata          = '0;
    rresp          = '0;
    #1;
    check_reset_state(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One table row per cycle, arready held at 1, rresp OKAY, rerr expected 0.
  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        rv;
    logic [31:0] rd;
    logic        e_aok;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic        e_dok;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[20];

  // Random-phase reference model: the ordered list of accepted fetches is the
  // outstanding set; the AXI slave answers whatever address the DUT issues.
  logic [31:0] acc_q[$];
  logic [31:0] slave_q[$];
  bit          m_ar_pend;
  logic [31:0] m_ar_addr;
  bit          m_dok;
  logic [31:0] m_rdata;
  logic        r_req, r_ardy, r_rv, e_aok;
  logic [31:0] r_addr, r_rd;

  initial begin
    // Single fetch, then fill to the limit and drain in order.
    vecs[0]  = '{1'b1, 32'hBFC0_0000, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 32'h3C1D_0000, 1'b0, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_0000, 1'b1, 32'h3C1D_0000};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_0000, 1'b0, 32'h3C1D_0000};
    vecs[6]  = '{1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h3C1D_0000};
    vecs[7]  = '{1'b1, 32'h4,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h3C1D_0000};
    vecs[8]  = '{1'b1, 32'h8,         1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 32'h3C1D_0000};
    vecs[9]  = '{1'b1, 32'hC,         1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b0, 32'h3C1D_0000};
    vecs[10] = '{1'b1, 32'h10,        1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         1'b0, 32'h3C1D_0000};
    vecs[11] = '{1'b1, 32'h10,        1'b0, 32'h0,         1'b0, 1'b0, 32'hC,         1'b0, 32'h3C1D_0000};
    vecs[12] = '{1'b1, 32'h10,        1'b1, 32'hA0,        1'b1, 1'b0, 32'hC,         1'b0, 32'h3C1D_0000};
    vecs[13] = '{1'b1, 32'h14,        1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        1'b1, 32'hA0};
    vecs[14] = '{1'b0, 32'h0,         1'b1, 32'hB0,        1'b0, 1'b0, 32'h10,        1'b0, 32'hA0};
    vecs[15] = '{1'b0, 32'h0,         1'b1, 32'hC0,        1'b0, 1'b0, 32'h10,        1'b1, 32'hB0};
    vecs[16] = '{1'b0, 32'h0,         1'b1, 32'hD0,        1'b0, 1'b0, 32'h10,        1'b1, 32'hC0};
    vecs[17] = '{1'b0, 32'h0,         1'b1, 32'hE0,        1'b0, 1'b0, 32'h10,        1'b1, 32'hD0};
    vecs[18] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h10,        1'b1, 32'hE0};
    vecs[19] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h10,        1'b0, 32'hE0};

    do_reset("rst0");
    check("const.arid",    32'(arid),    32'd0);
    check("const.arlen",   32'(arlen),   32'd0);
    check("const.arburst", 32'(arburst), 32'd1);
    check("const.arlock",  32'(arlock),  32'd0);
    check("const.arcache", 32'(arcache), 32'd0);
    check("const.arprot",  32'(arprot),  32'd0);

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].req, vecs[i].addr, 1'b1, vecs[i].rv, vecs[i].rd, 2'b00);
      expect_out($sformatf("vec%0d", i), vecs[i].e_aok, vecs[i].e_arv,
                 vecs[i].e_araddr, vecs[i].e_dok, vecs[i].e_rdata, 1'b0);
    end
    check("arsize_fetch", 32'(arsize), 32'd2);
    check("rready_up",    32'(rready), 32'd1);

    // AR stall: address held, no new accept until arready.
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 2'b00); expect_out("stall0", 1, 0, 32'h10,  0, 32'hE0, 0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 2'b00); expect_out("stall1", 0, 1, 32'h100, 0, 32'hE0, 0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 2'b00); expect_out("stall2", 0, 1, 32'h100, 0, 32'hE0, 0);
    cyc(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 2'b00); expect_out("stall3", 0, 1, 32'h100, 0, 32'hE0, 0);
    cyc(1'b1, 32'h104, 1'b1, 1'b0, 32'h0, 2'b00); expect_out("stall4", 1, 1, 32'h100, 0, 32'hE0, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 2'b00); expect_out("stall5", 0, 1, 32'h104, 0, 32'hE0, 0);

    // Third outstanding request, then three back-to-back R beats.
    cyc(1'b1, 32'h108, 1'b1, 1'b0, 32'h0,  2'b00); expect_out("ord0", 1, 0, 32'h104, 0, 32'hE0, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  2'b00); expect_out("ord1", 0, 1, 32'h108, 0, 32'hE0, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'h11, 2'b00); expect_out("ord2", 0, 0, 32'h108, 0, 32'hE0, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'h22, 2'b00); expect_out("ord3", 0, 0, 32'h108, 1, 32'h11, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'h33, 2'b00); expect_out("ord4", 0, 0, 32'h108, 1, 32'h22, 0);
    idle();                                        expect_out("ord5", 0, 0, 32'h108, 1, 32'h33, 0);
    idle();                                        expect_out("ord6", 0, 0, 32'h108, 0, 32'h33, 0);

    // R beat with nothing outstanding: flagged, not forwarded, count stays 0.
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'h77, 2'b00); expect_out("spur0", 0, 0, 32'h108, 0, 32'h33, 0);
    idle();                                        expect_out("spur1", 0, 0, 32'h108, 0, 32'h33, 1);
    cyc(1'b1, 32'h500, 1'b1, 1'b0, 32'h0,  2'b00); expect_out("spur2", 1, 0, 32'h108, 0, 32'h33, 1);
    cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  2'b00); expect_out("spur3", 0, 1, 32'h500, 0, 32'h33, 1);
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'h55, 2'b00); expect_out("spur4", 0, 0, 32'h500, 0, 32'h33, 1);
    idle();                                        expect_out("spur5", 0, 0, 32'h500, 1, 32'h55, 1);

    do_reset("rst1");

    // Error response: data still delivered, rerr sticky.
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 32'h0,        2'b00); expect_out("resp0", 1, 0, 32'h0,   0, 32'h0, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        2'b00); expect_out("resp1", 0, 1, 32'h200, 0, 32'h0, 0);
    cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'hDEADBEEF, 2'b10); expect_out("resp2", 0, 0, 32'h200, 0, 32'h0, 0);
    idle();                                              expect_out("resp3", 0, 0, 32'h200, 1, 32'hDEADBEEF, 1);
    idle();                                              expect_out("resp4", 0, 0, 32'h200, 0, 32'hDEADBEEF, 1);

    // Two outstanding with an AR pending, then reset between clock edges.
    cyc(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 2'b00); expect_out("mf0", 1, 0, 32'h200, 0, 32'hDEADBEEF, 1);
    cyc(1'b1, 32'h304, 1'b1, 1'b0, 32'h0, 2'b00); expect_out("mf1", 1, 1, 32'h300, 0, 32'hDEADBEEF, 1);
    @(posedge clk);
    #1;
    inst_sram_req = 1'b0;
    arready       = 1'b0;
    check("mf2.arvalid", 32'(arvalid), 32'd1);
    check("mf2.araddr",  araddr, 32'h304);
    check("mf2.rerr",    32'(inst_sram_rerr), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("mf_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    cyc(1'b1, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0,         2'b00); expect_out("rf0", 1, 0, 32'h0,         0, 32'h0, 0);
    cyc(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         2'b00); expect_out("rf1", 0, 1, 32'hBFC0_0000, 0, 32'h0, 0);
    idle();                                                     expect_out("rf2", 0, 0, 32'hBFC0_0000, 0, 32'h0, 0);
    cyc(1'b0, 32'h0,         1'b1, 1'b1, 32'h3C1D_0000, 2'b00); expect_out("rf3", 0, 0, 32'hBFC0_0000, 0, 32'h0, 0);
    idle();                                                     expect_out("rf4", 0, 0, 32'hBFC0_0000, 1, 32'h3C1D_0000, 0);
    idle();                                                     expect_out("rf5", 0, 0, 32'hBFC0_0000, 0, 32'h3C1D_0000, 0);

    // Randomized traffic against the reference model.
    m_ar_pend = 1'b0;
    m_ar_addr = '0;
    m_dok     = 1'b0;
    m_rdata   = '0;
    for (int i = 0; i < 600; i++) begin
      r_req  = ($urandom_range(0, 9) < 6);
      r_addr = $urandom() & 32'hFFFF_FFFC;
      r_ardy = ($urandom_range(0, 9) < 7);
      r_rv   = (slave_q.size() > 0) && ($urandom_range(0, 9) < 5);
      r_rd   = r_rv ? (slave_q[0] ^ KEY) : $urandom();
      cyc(r_req, r_addr, r_ardy, r_rv, r_rd, 2'b00);

      e_aok = r_req && (!m_ar_pend || r_ardy) && ((acc_q.size() < MAX_OUT) || r_rv);
      check($sformatf("rnd%0d.addr_ok", i), 32'(inst_sram_addr_ok), 32'(e_aok));
      check($sformatf("rnd%0d.arvalid", i), 32'(arvalid), 32'(m_ar_pend));
      if (m_ar_pend) check($sformatf("rnd%0d.araddr", i), araddr, m_ar_addr);
      check($sformatf("rnd%0d.data_ok", i), 32'(inst_sram_data_ok), 32'(m_dok));
      if (m_dok) check($sformatf("rnd%0d.rdata", i), inst_sram_rdata, m_rdata);
      check($sformatf("rnd%0d.rerr", i), 32'(inst_sram_rerr), 32'd0);

      // AXI slave: remember what the DUT actually issued.
      if (r_rv) void'(slave_q.pop_front());
      if (arvalid && r_ardy) slave_q.push_back(araddr);

      // Reference: each response answers the oldest accepted fetch.
      m_dok = r_rv;
      if (r_rv) begin
        if (acc_q.size() > 0) m_rdata = acc_q.pop_front() ^ KEY;
      end
      if (m_ar_pend && r_ardy) m_ar_pend = 1'b0;
      if (e_aok) begin
        m_ar_pend = 1'b1;
        m_ar_addr = r_addr;
        acc_q.push_back(r_addr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
